// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states and the latched descriptor.
package i2c_pkg;

    localparam int unsigned I2C_DEV_W     = 7;
    localparam int unsigned I2C_REG_W     = 8;
    // Storage width for the length field; the arbiter's LEN_W may not exceed it.
    localparam int unsigned I2C_LEN_MAX_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LAUNCH,
        WAIT,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic [I2C_DEV_W-1:0]     dev_addr;
        logic [I2C_REG_W-1:0]     reg_addr;
        logic                     rw;
        logic [I2C_LEN_MAX_W-1:0] len;
    } i2c_desc_t;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester and engine signals of the I2C transaction arbiter.
// slave: the arbiter's view; master: the surrounding clients and engine.
interface i2c_txn_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 6
);
    import i2c_pkg::*;

    logic [N_REQ-1:0]           req;
    logic [N_REQ*I2C_DEV_W-1:0] req_dev_addr;
    logic [N_REQ*I2C_REG_W-1:0] req_reg_addr;
    logic [N_REQ-1:0]           req_rw;
    logic [N_REQ*LEN_W-1:0]     req_len;
    logic [N_REQ-1:0]           gnt;
    logic [N_REQ-1:0]           done;
    logic                       err;

    logic                       eng_start;
    logic [I2C_DEV_W-1:0]       eng_dev_addr;
    logic [I2C_REG_W-1:0]       eng_reg_addr;
    logic                       eng_rw;
    logic [LEN_W-1:0]           eng_len;
    logic                       eng_busy;
    logic                       eng_done;
    logic                       eng_nack;
    logic                       eng_abort;

    modport slave (
        input  req, req_dev_addr, req_reg_addr, req_rw, req_len,
        input  eng_busy, eng_done, eng_nack,
        output gnt, done, err,
        output eng_start, eng_dev_addr, eng_reg_addr, eng_rw, eng_len, eng_abort
    );

    modport master (
        output req, req_dev_addr, req_reg_addr, req_rw, req_len,
        output eng_busy, eng_done, eng_nack,
        input  gnt, done, err,
        input  eng_start, eng_dev_addr, eng_reg_addr, eng_rw, eng_len, eng_abort
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, wrapping at N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick_c,
    output logic [PW-1:0]    idx_c,
    output logic             found_c
);

    logic [PW:0] cand;

    // Wrap by explicit compare so non-power-of-2 N_REQ rotates correctly.
    always_comb begin
        pick_c  = '0;
        idx_c   = '0;
        found_c = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (PW+1)'(ptr) + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (!found_c && req[cand[PW-1:0]]) begin
                found_c = 1'b1;
                idx_c   = cand[PW-1:0];
            end
        end
        if (found_c) begin
            pick_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer sharing one I2C transaction engine between N_REQ requesters.
// Optional watchdog/abort enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned LEN_W       = 6,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic              clk,
    input logic              rst,
    i2c_txn_arbiter_if.slave bus
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || LEN_W > I2C_LEN_MAX_W ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_cfg_check
        $error("i2c_txn_arbiter: unsupported parameter combination");
    end

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    i2c_desc_t        desc_q, desc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0]      cnt_q, cnt_d;
    logic             abort_q, abort_d;
`endif

    logic [N_REQ-1:0] pick_c;
    logic [PW-1:0]    pick_idx_c;
    logic             found_c;
    logic [LEN_W-1:0] len_c;
    i2c_desc_t        win_desc_c;
    logic             len_unused_c;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .pick_c  (pick_c),
        .idx_c   (pick_idx_c),
        .found_c (found_c)
    );

    // Winner's descriptor; a zero length is launched as a single byte.
    always_comb begin
        len_c               = bus.req_len[LEN_W*pick_idx_c +: LEN_W];
        win_desc_c.dev_addr = bus.req_dev_addr[I2C_DEV_W*pick_idx_c +: I2C_DEV_W];
        win_desc_c.reg_addr = bus.req_reg_addr[I2C_REG_W*pick_idx_c +: I2C_REG_W];
        win_desc_c.rw       = bus.req_rw[pick_idx_c];
        win_desc_c.len      = (len_c == '0) ? I2C_LEN_MAX_W'(1) : I2C_LEN_MAX_W'(len_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            desc_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            desc_q  <= desc_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        desc_d  = desc_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req && !bus.eng_busy) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                // A request withdrawn before arbitration simply returns to idle.
                if (found_c) begin
                    gnt_d   = pick_c;
                    win_d   = pick_idx_c;
                    desc_d  = win_desc_c;
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                // Counter holds the number of cycles elapsed since eng_start.
                cnt_d   = 16'd1;
`endif
            end
            WAIT: begin
                if (bus.eng_done) begin
                    done_d  = gnt_q;
                    err_d   = bus.eng_nack;
                    state_d = DONE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign len_unused_c     = ^desc_q.len;
    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.eng_start    = start_q;
    assign bus.eng_dev_addr = desc_q.dev_addr;
    assign bus.eng_reg_addr = desc_q.reg_addr;
    assign bus.eng_rw       = desc_q.rw;
    assign bus.eng_len      = desc_q.len[LEN_W-1:0];
`ifdef I2C_ARB_TIMEOUT_EN
    assign bus.eng_abort    = abort_q;
`else
    assign bus.eng_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter; the timeout scenario runs when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_txn_arbiter;
    import i2c_pkg::*;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LEN_W = 6;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = 64;
`else
    localparam int unsigned TIMEOUT_CYC = 4096;
`endif

    typedef struct {
        logic [3:0] gnt;
        logic [6:0] dev;
        logic [7:0] rg;
        logic       rw;
        logic [5:0] len;
        int         cyc;
    } start_t;

    typedef struct {
        logic [3:0] done;
        logic       err;
        logic       abort;
        int         cyc;
    } done_t;

    typedef struct {
        int   lat;
        logic nack;
    } eng_cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bus ();

    i2c_txn_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] pk_req;
    logic [1:0] pk_ptr;
    logic [3:0] pk_pick;
    logic [1:0] pk_idx;
    logic       pk_found;

    rr_pick #(.N_REQ(4), .PW(2)) u_pick (
        .req     (pk_req),
        .ptr     (pk_ptr),
        .pick_c  (pk_pick),
        .idx_c   (pk_idx),
        .found_c (pk_found)
    );

    start_t   exp_start_q[$];
    done_t    exp_done_q[$];
    eng_cfg_t eng_cfg_q[$];

    int cyc        = 0;
    int n_start    = 0;
    int n_done     = 0;
    int last_start = -1;
    int passed     = 0;
    int total      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req_v);
        total++;
        if (act == req_v) passed++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req_v, cyc);
    endtask

    task automatic push_start(input logic [3:0] g, input logic [6:0] d, input logic [7:0] r,
                              input logic w, input logic [5:0] l, input int c);
        exp_start_q.push_back('{gnt: g, dev: d, rg: r, rw: w, len: l, cyc: c});
    endtask

    task automatic push_done(input logic [3:0] d, input logic e, input logic a, input int c);
        exp_done_q.push_back('{done: d, err: e, abort: a, cyc: c});
    endtask

    task automatic push_cfg(input int lat, input logic nack);
        eng_cfg_q.push_back('{lat: lat, nack: nack});
    endtask

    task automatic set_desc(input int i, input logic [6:0] d, input logic [7:0] r,
                            input logic w, input logic [5:0] l);
        bus.req_dev_addr[7*i +: 7]     = d;
        bus.req_reg_addr[8*i +: 8]     = r;
        bus.req_rw[i]                  = w;
        bus.req_len[LEN_W*i +: LEN_W]  = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        last_start = -1;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, (n_done >= target) ? 1 : 0, 1);
    endtask

    // Engine model: answers each launch after a configured latency; negative latency stays silent.
    initial begin
        eng_cfg_t cfg;
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.eng_start) begin
                cfg = (eng_cfg_q.size() > 0) ? eng_cfg_q.pop_front() : '{lat: -1, nack: 1'b0};
                if (cfg.lat > 0) begin
                    repeat (cfg.lat) @(posedge clk);
                    #1;
                    bus.eng_done = 1'b1;
                    bus.eng_nack = cfg.nack;
                    @(posedge clk);
                    #1;
                    bus.eng_done = 1'b0;
                    bus.eng_nack = 1'b0;
                end
            end
        end
    end

    // Monitor: pops and compares on every launch and every done pulse.
    always @(negedge clk) begin
        start_t s;
        done_t  d;
        if (!rst) begin
            if (bus.eng_start) begin
                n_start++;
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_eng_start", 1, 0);
                end else begin
                    s = exp_start_q.pop_front();
                    chk("start_gnt", int'(bus.gnt), int'(s.gnt));
                    chk("start_gnt_onehot", $countones(bus.gnt), 1);
                    chk("eng_dev_addr", int'(bus.eng_dev_addr), int'(s.dev));
                    chk("eng_reg_addr", int'(bus.eng_reg_addr), int'(s.rg));
                    chk("eng_rw", int'(bus.eng_rw), int'(s.rw));
                    chk("eng_len", int'(bus.eng_len), int'(s.len));
                    if (s.cyc >= 0) chk("start_cycle", cyc, s.cyc);
                    if (last_start >= 0) chk("start_gap_ok", (cyc - last_start >= 2) ? 1 : 0, 1);
                    last_start = cyc;
                end
            end
            if (bus.done != 4'b0000) begin
                n_done++;
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_vec", int'(bus.done), int'(d.done));
                    chk("done_err", int'(bus.err), int'(d.err));
                    chk("done_abort", int'(bus.eng_abort), int'(d.abort));
                    chk("done_gnt_same", int'(bus.gnt), int'(d.done));
                    if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;
        int base;
        int base_s;
        logic [3:0] pv_req[5];
        logic [1:0] pv_ptr[5];
        logic [3:0] pv_exp[5];

        bus.req          = '0;
        bus.req_dev_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_rw       = '0;
        bus.req_len      = '0;
        bus.eng_busy     = 1'b0;
        pk_req           = '0;
        pk_ptr           = '0;

        do_reset();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_eng_start", int'(bus.eng_start), 0);
        chk("rst_eng_abort", int'(bus.eng_abort), 0);
        chk("rst_eng_dev_addr", int'(bus.eng_dev_addr), 0);
        chk("rst_eng_len", int'(bus.eng_len), 0);

        // Picker unit vectors: {req, ptr} -> one-hot pick.
        pv_req = '{4'b0000, 4'b1111, 4'b0011, 4'b1000, 4'b0110};
        pv_ptr = '{2'd0,    2'd2,    2'd2,    2'd0,    2'd3};
        pv_exp = '{4'b0000, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            pk_req = pv_req[i];
            pk_ptr = pv_ptr[i];
            #1;
            chk("pick_onehot", int'(pk_pick), int'(pv_exp[i]));
            chk("pick_found", int'(pk_found), (pv_exp[i] != 4'b0000) ? 1 : 0);
            if (pk_found) chk("pick_idx_matches", int'(4'b0001 << pk_idx), int'(pv_exp[i]));
        end

        // Single read request with exact latencies.
        set_desc(0, 7'h50, 8'h50, 1'b1, 6'd8);
        @(posedge clk); #1;
        c = cyc;
        bus.req = 4'b0001;
        push_cfg(38, 1'b0);
        push_start(4'b0001, 7'h50, 8'h50, 1'b1, 6'd8, c + 2);
        push_done(4'b0001, 1'b0, 1'b0, c + 41);
        base = n_done;
        wait_dones(base + 1, 100, "single_completed");
        bus.req = 4'b0000;

        // All four requesting: strict rotation from pointer 0; len 0 launches as 1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_desc(i, 7'(8'h10 + i), 8'(8'hA0 + i), 1'(i), 6'(i));
        end
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            push_cfg(4, 1'b0);
            push_start(4'(1 << w), 7'(8'h10 + w), 8'(8'hA0 + w), 1'(w), (w == 0) ? 6'd1 : 6'(w), -1);
            push_done(4'(1 << w), 1'b0, 1'b0, -1);
        end
        base = n_done;
        @(posedge clk); #1;
        bus.req = 4'b1111;
        wait_dones(base + 5, 200, "rotation_completed");
        bus.req = 4'b0000;

        // NACK on requester 2, then pointer sits at 3.
        set_desc(2, 7'h22, 8'h33, 1'b0, 6'd5);
        push_cfg(6, 1'b1);
        push_start(4'b0100, 7'h22, 8'h33, 1'b0, 6'd5, -1);
        push_done(4'b0100, 1'b1, 1'b0, -1);
        base = n_done;
        @(posedge clk); #1;
        bus.req = 4'b0100;
        wait_dones(base + 1, 100, "nack_completed");
        bus.req = 4'b0000;

        set_desc(3, 7'h3C, 8'h01, 1'b1, 6'd63);
        set_desc(0, 7'h0A, 8'hFF, 1'b0, 6'd2);
        push_cfg(3, 1'b0);
        push_cfg(3, 1'b0);
        push_start(4'b1000, 7'h3C, 8'h01, 1'b1, 6'd63, -1);
        push_done(4'b1000, 1'b0, 1'b0, -1);
        push_start(4'b0001, 7'h0A, 8'hFF, 1'b0, 6'd2, -1);
        push_done(4'b0001, 1'b0, 1'b0, -1);
        base = n_done;
        @(posedge clk); #1;
        bus.req = 4'b1001;
        wait_dones(base + 2, 100, "ptr_after_nack_completed");
        bus.req = 4'b0000;

        // External engine owner stalls arbitration.
        set_desc(1, 7'h11, 8'h22, 1'b0, 6'd4);
        @(posedge clk); #1;
        bus.eng_busy = 1'b1;
        bus.req      = 4'b0010;
        base_s       = n_start;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_stall_no_start", n_start, base_s);
        c = cyc;
        bus.eng_busy = 1'b0;
        push_cfg(5, 1'b0);
        push_start(4'b0010, 7'h11, 8'h22, 1'b0, 6'd4, c + 2);
        push_done(4'b0010, 1'b0, 1'b0, -1);
        base = n_done;
        wait_dones(base + 1, 100, "busy_completed");
        bus.req = 4'b0000;

        // Async reset while waiting on the engine.
        set_desc(0, 7'h55, 8'h66, 1'b1, 6'd7);
        @(posedge clk); #1;
        c = cyc;
        bus.req = 4'b0001;
        push_cfg(-1, 1'b0);
        push_start(4'b0001, 7'h55, 8'h66, 1'b1, 6'd7, c + 2);
        base = n_done;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_gnt", int'(bus.gnt), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_eng_dev_addr", int'(bus.eng_dev_addr), 0);
        chk("arst_eng_reg_addr", int'(bus.eng_reg_addr), 0);
        chk("arst_eng_rw", int'(bus.eng_rw), 0);
        chk("arst_eng_len", int'(bus.eng_len), 0);
        bus.req = 4'b0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        last_start = -1;
        repeat (20) @(posedge clk);
        #1;
        chk("arst_no_done_after_release", n_done, base);

`ifdef I2C_ARB_TIMEOUT_EN
        // Silent engine: abort and error after TIMEOUT_CYC; the late eng_done is dropped.
        @(posedge clk); #1;
        c = cyc;
        bus.req = 4'b0001;
        push_cfg(100, 1'b0);
        push_start(4'b0001, 7'h55, 8'h66, 1'b1, 6'd7, c + 2);
        push_done(4'b0001, 1'b1, 1'b1, c + 2 + 64);
        base = n_done;
        wait_dones(base + 1, 200, "timeout_completed");
        bus.req = 4'b0000;
        base = n_done;
        repeat (120) @(posedge clk);
        #1;
        chk("late_eng_done_ignored", n_done, base);
`endif

        chk("start_queue_drained", exp_start_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
